// File: rtl/i2c_slave_tx_pkg.sv
// Shared I2C definitions: transmit FSM state type, ACK/NACK bus levels, default byte width.
package i2c_pkg;

    localparam int unsigned I2C_DATA_W = 8;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ACK   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/i2c_slave_tx_if.sv
// Handshake and SDA signals between the slave controller and the transmit serializer.
interface i2c_slave_tx_if
    import i2c_pkg::*;
#(
    parameter int unsigned DATA_W = I2C_DATA_W
);
    logic              en;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              sda_in;
    logic              sda_drive_low;
    logic              byte_done;
    logic              nack;
    logic              underrun;

    modport slave (
        input  en, tx_data, tx_valid, sda_in,
        output tx_ready, sda_drive_low, byte_done, nack, underrun
    );

    modport master (
        output en, tx_data, tx_valid, sda_in,
        input  tx_ready, sda_drive_low, byte_done, nack, underrun
    );
endinterface

// File: rtl/i2c_slave_tx_bit_counter.sv
// Saturating bit counter clocked on SCL falling edges; clr together with inc restarts at 1.
module i2c_bit_counter #(
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned CNT_W  = $clog2(DATA_W + 2)
) (
    input  logic             SCL,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

    always_ff @(negedge SCL or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && !last) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_MAX);
endmodule

// File: rtl/i2c_slave_tx.sv
// I2C slave-transmit serializer: shifts bytes MSB first as open-drain drive-low, then samples the master ACK.
// Optional debug ports dbg_state/dbg_cnt are present when I2C_TX_DBG_EN is defined.
module i2c_slave_tx
    import i2c_pkg::*;
#(
    parameter  int unsigned DATA_W = I2C_DATA_W,
    localparam int unsigned CNT_W  = $clog2(DATA_W + 2)
) (
    input  logic             SCL,
    input  logic             reset,
    i2c_slave_tx_if.slave    bus
`ifdef I2C_TX_DBG_EN
    ,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_cnt
`endif
);
    tx_state_t         state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              drv_nxt, ready_nxt, done_nxt, nack_nxt, under_nxt;
    logic              cnt_clr, cnt_inc, cnt_last;
    logic [CNT_W-1:0]  cnt;

    i2c_bit_counter #(.DATA_W(DATA_W)) u_cnt (
        .SCL   (SCL),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        drv_nxt   = 1'b0;
        ready_nxt = 1'b0;
        done_nxt  = 1'b0;
        nack_nxt  = 1'b0;
        under_nxt = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en && bus.tx_valid) begin
                    shreg_nxt = bus.tx_data;
                    drv_nxt   = ~bus.tx_data[DATA_W-1];
                    ready_nxt = 1'b1;
                    cnt_inc   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!bus.en) begin
                    state_nxt = IDLE;
                    cnt_clr   = 1'b1;
                end else if (cnt_last) begin
                    state_nxt = ACK;
                end else begin
                    shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
                    drv_nxt   = ~shreg[DATA_W-2];
                    cnt_inc   = 1'b1;
                end
            end
            ACK: begin
                // Abort outranks the ACK sample when en drops on the sampling edge.
                if (!bus.en) begin
                    state_nxt = IDLE;
                    cnt_clr   = 1'b1;
                end else begin
                    done_nxt = 1'b1;
                    if (bus.sda_in == I2C_NACK) begin
                        nack_nxt  = 1'b1;
                        state_nxt = IDLE;
                        cnt_clr   = 1'b1;
                    end else if (bus.tx_valid) begin
                        shreg_nxt = bus.tx_data;
                        drv_nxt   = ~bus.tx_data[DATA_W-1];
                        ready_nxt = 1'b1;
                        cnt_clr   = 1'b1;
                        cnt_inc   = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        under_nxt = 1'b1;
                        state_nxt = IDLE;
                        cnt_clr   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(negedge SCL or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            shreg             <= '0;
            bus.sda_drive_low <= 1'b0;
            bus.tx_ready      <= 1'b0;
            bus.byte_done     <= 1'b0;
            bus.nack          <= 1'b0;
            bus.underrun      <= 1'b0;
        end else begin
            state             <= state_nxt;
            shreg             <= shreg_nxt;
            bus.sda_drive_low <= drv_nxt;
            bus.tx_ready      <= ready_nxt;
            bus.byte_done     <= done_nxt;
            bus.nack          <= nack_nxt;
            bus.underrun      <= under_nxt;
        end
    end

`ifdef I2C_TX_DBG_EN
    assign dbg_state = state;
    assign dbg_cnt   = cnt;
`endif
endmodule

// File: doc/i2c_slave_tx.md
Name: i2c_slave_tx

Overview:
- Slave-transmit serializer for the I2C slave.
- Takes a parallel byte over a valid/ready handshake and shifts it onto SDA, MSB first, as open-drain drive-low.
- Releases SDA for the master's ACK slot, samples ACK/NACK, and either chains the next byte or returns to idle.
- Sits beside the receive path. The slave controller asserts en during a read transaction, after the address+R ACK.

Parameters:
- DATA_W, 8, byte width in bits shifted per transfer; the ACK slot follows bit 0.
- CNT_W, $clog2(DATA_W+2), width of the internal bit counter (derived; do not override).

Ports:
- SCL  in  1  bus clock; all flops update on the falling edge of SCL.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  read phase active (from slave controller); low aborts.
- tx_data  in  DATA_W  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  one-cycle pulse: tx_data accepted on this edge.
- sda_in  in  1  synchronized SDA level (master ACK=0, NACK=1).
- sda_drive_low  out  1  1 = pull SDA low; 0 = release (high-Z, reads 1).
- byte_done  out  1  one-cycle tick: ACK slot sampled for the current byte.
- nack  out  1  one-cycle pulse: master NACKed; transfer ended.
- underrun  out  1  one-cycle pulse: master ACKed but no tx_valid.

Behaviour:
- Reset (async, any time): state=IDLE, shift register=0, bit count=0. All outputs 0; SDA released.
- States: IDLE, SHIFT, ACK. "Edge" below means a falling edge of SCL.
- IDLE:
  - If en && tx_valid: load shift register, pulse tx_ready, sda_drive_low=~tx_data[DATA_W-1], cnt=1, go SHIFT.
  - Otherwise hold IDLE with SDA released.
- SHIFT:
  - Each edge presents the next bit, MSB→LSB: sda_drive_low = ~bit, cnt++.
  - When cnt==DATA_W on entry to the edge, bit 0 has been presented. That edge releases SDA and goes to ACK.
- ACK: the next edge samples sda_in. The master has held it through SCL high. On that edge byte_done=1, plus:
  - sda_in=0, en=1, tx_valid=1: load next byte, pulse tx_ready, present its MSB, cnt=1, stay SHIFT. This gives back-to-back bytes with no idle edge.
  - sda_in=0 and tx_valid=0: pulse underrun, release SDA, go IDLE. The master then reads 0xFF.
  - sda_in=1: pulse nack, release SDA, go IDLE. tx_valid is ignored and no data is consumed.
- Latency: tx_ready is on the same edge the MSB is driven. A byte occupies DATA_W+1 SCL periods including the ACK slot.
- en low on any edge in SHIFT or ACK: go IDLE and release SDA. No byte_done, nack or underrun. This is a mid-byte abort, e.g. on STOP or repeated START.
- en low has priority over the ACK sample when both occur on the same edge.
- tx_data is captured only when tx_ready=1. Later changes to tx_data do not affect the byte in flight.
- sda_drive_low is registered and glitch-free. It never asserts in IDLE or during the ACK slot.
- Counter saturates at DATA_W and never wraps mid-byte. It clears to 0 on entry to IDLE.

Optional Feature:
- Macro: I2C_TX_DBG_EN.
- Defined: adds outputs dbg_state[1:0] (IDLE=0, SHIFT=1, ACK=2) and dbg_cnt[CNT_W-1:0], both registered copies for simulation/ILA.
- Undefined: these ports and their logic are absent. Functional behaviour is identical.

Decomposition:
- Package i2c_pkg holds:
  - the state typedef (tx_state_t: IDLE, SHIFT, ACK);
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1;
  - the default DATA_W=8, shared with the receive path.
- One sub-module, i2c_bit_counter, a falling-edge saturating counter:
  - inputs clr, inc;
  - outputs cnt and last (cnt==DATA_W);
  - async active-high reset.

Test Plan:
- Reset mid-SHIFT (after 3 bits of 0xA5) → all outputs 0 immediately and state IDLE. The next en&&tx_valid restarts cleanly from the MSB.
- en=1, tx_data=0xA5, valid → tx_ready on edge 0. sda_drive_low across edges 0..7 = 0,1,0,1,1,0,1,0. Released on edge 8. byte_done on edge 9.
- Two bytes 0x3C then 0xFF, master ACKs the first → second MSB driven on the same edge as first byte_done, second tx_ready there. No gap edge.
- Master NACK (sda_in=1) after 0x81 → nack and byte_done on edge 9, return to IDLE. tx_valid=1 with 0x42 is not accepted (no tx_ready).
- ACK with tx_valid=0 after 0x55 → underrun on edge 9, IDLE, sda_drive_low stays 0.
- en dropped at edge 4 of 0xF0 → IDLE on that edge, SDA released. No byte_done, nack or underrun.
